// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command sequencer for an external zero-fill N-bit shift register
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; ready only while idle
//   cmd_data/dir/amt      word to load, 0 = right / 1 = left, shift count (saturates at N)
//   abort                 cancels an in-flight command, no done pulse
//   sr_sel/sr_in          datapath select (00 hold, 01 load, 10 right, 11 left) and load word
//   sr_q                  datapath register output
//   busy/done/result      in-flight flag, one-cycle completion pulse, captured final word
module shift_seq_ctrl #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N-1:0]     cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic             abort,
  output logic [1:0]       sr_sel,
  output logic [N-1:0]     sr_in,
  input  logic [N-1:0]     sr_q,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     result
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_SHR  = 2'b10;
  localparam logic [1:0] SEL_SHL  = 2'b11;

  localparam logic [CNT_W-1:0] AMT_MAX = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       sel_q, sel_d;
  logic [N-1:0]     in_q, in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N-1:0]     result_q, result_d;

  assign cmd_ready = (state_q == S_IDLE);
  assign sr_sel    = sel_q;
  assign sr_in     = in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    in_d     = in_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_LOAD;
          in_d    = cmd_data;
          dir_d   = cmd_dir;
          cnt_d   = (cmd_amt > AMT_MAX) ? AMT_MAX : cmd_amt;
        end
      end
      S_LOAD: begin
        state_d = (cnt_q == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end
      end
      default: begin
        // sr_q already carries the final shifted word during this cycle.
        state_d  = S_IDLE;
        result_d = sr_q;
        done_d   = 1'b1;
      end
    endcase

    // Abort overrides everything above, including the DONE capture.
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result_q;
      done_d   = 1'b0;
    end

    // Datapath controls are registered from the next state so they line up
    // with the state they belong to.
    case (state_d)
      S_LOAD:  sel_d = SEL_LOAD;
      S_SHIFT: sel_d = dir_d ? SEL_SHL : SEL_SHR;
      default: sel_d = SEL_HOLD;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      sel_q    <= SEL_HOLD;
      in_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      sel_q    <= sel_d;
      in_q     <= in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - scoreboard bench for shift_seq_ctrl driving a zero-fill shift register
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_dir;
  logic [3:0] cmd_amt;
  logic       abort;
  logic [1:0] sr_sel;
  logic [7:0] sr_in;
  logic [7:0] sr_q;
  logic       busy;
  logic       done;
  logic [7:0] result;

  logic [7:0] dp_q = 8'h00;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  typedef struct {
    logic [7:0] res;
    int         acc;
    int         lat;
  } exp_t;

  exp_t sb[$];

  shift_seq_ctrl #(.N(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_amt   (cmd_amt),
    .abort     (abort),
    .sr_sel    (sr_sel),
    .sr_in     (sr_in),
    .sr_q      (sr_q),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Zero-fill shift register datapath, not cleared by reset.
  always @(posedge clk) begin
    case (sr_sel)
      2'b01:   dp_q <= sr_in;
      2'b10:   dp_q <= dp_q >> 1;
      2'b11:   dp_q <= dp_q << 1;
      default: dp_q <= dp_q;
    endcase
  end
  assign sr_q = dp_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {24'd0, result}, {24'd0, e.res});
        check("latency", cyc - e.acc, e.lat);
      end
    end
  end

  // Present a command at the current negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [7:0] d, input logic dir, input logic [3:0] amt,
                       input bit push, input logic [7:0] exp_res, input int exp_lat);
    exp_t e;
    check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_amt   = amt;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (push) begin
      e.res = exp_res;
      e.acc = cyc;
      e.lat = exp_lat;
      sb.push_back(e);
    end
  endtask

  // Full command with sel sequence checks; returns at the negedge of the done cycle.
  task automatic run_cmd(input logic [7:0] d, input logic dir, input logic [3:0] amt,
                         input int nshift, input logic [7:0] exp_res);
    issue(d, dir, amt, 1'b1, exp_res, nshift + 2);
    check("sel_load", {30'd0, sr_sel}, 32'd1);
    check("sr_in_load", {24'd0, sr_in}, {24'd0, d});
    check("busy_load", {31'd0, busy}, 32'd1);
    for (int i = 0; i < nshift; i++) begin
      @(negedge clk);
      check("sel_shift", {30'd0, sr_sel}, dir ? 32'd3 : 32'd2);
    end
    @(negedge clk);
    check("sel_done_state", {30'd0, sr_sel}, 32'd0);
    check("busy_done_state", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("ready_in_done_cycle", {31'd0, cmd_ready}, 32'd1);
    check("busy_in_done_cycle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    cmd_dir   = 1'b0;
    cmd_amt   = 4'd0;
    abort     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sel", {30'd0, sr_sel}, 32'd0);
    check("rst_sr_in", {24'd0, sr_in}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    run_cmd(8'h0F, 1'b0, 4'd2, 2, 8'h03);
    @(negedge clk);
    run_cmd(8'h0F, 1'b1, 4'd3, 3, 8'h78);
    @(negedge clk);
    run_cmd(8'hFF, 1'b1, 4'd12, 8, 8'h00);
    @(negedge clk);
    run_cmd(8'h04, 1'b0, 4'd0, 0, 8'h04);
    @(negedge clk);

    // Abort in the second SHIFT cycle of a 5-place shift.
    issue(8'h3C, 1'b0, 4'd5, 1'b0, 8'h00, 0);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_sel", {30'd0, sr_sel}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    repeat (6) @(negedge clk);
    check("abort_result_kept", {24'd0, result}, 32'h04);

    // Abort held high in IDLE while a command arrives: command is accepted.
    abort = 1'b1;
    issue(8'h81, 1'b1, 4'd1, 1'b1, 8'h02, 3);
    abort = 1'b0;
    check("abort_idle_accept_busy", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);

    // Back-to-back: second command accepted in the done cycle of the first.
    run_cmd(8'h0F, 1'b1, 4'd1, 1, 8'h1E);
    run_cmd(8'h14, 1'b0, 4'd2, 2, 8'h05);
    repeat (2) @(negedge clk);
    check("b2b_result_held", {24'd0, result}, 32'h05);

    // Reset in the middle of a shift.
    issue(8'hAA, 1'b0, 4'd8, 1'b1, 8'h00, 10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_sel", {30'd0, sr_sel}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", {24'd0, result}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    check("midrst_busy_after", {31'd0, busy}, 32'd0);
    repeat (12) @(negedge clk);
    check("midrst_no_done_result", {24'd0, result}, 32'd0);
    check("missing_done", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
